// File: rtl/cpu_fetch_pkg.sv
// Shared types and width helpers for the instruction prefetch unit.
package cpu_fetch_pkg;

  typedef enum logic {
    COLD  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Widest PC an in-flight entry can carry; narrower PCs are zero-extended.
  localparam int MAX_PCW = 32;

  typedef struct packed {
    logic               valid;
    logic [MAX_PCW-1:0] pc;
  } inflight_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head word is visible combinationally.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int WIDTH = 51,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Flush wins over both push and pop in the same cycle.
  assign w_do_pop  = i_pop && !i_flush && !o_empty;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cpu_prefetch_unit.sv
// Sequential instruction prefetcher with credit-based issue, in-flight tracking and redirect flush.
// Optional performance counters are enabled by defining CPU_PREFETCH_PERF_EN.
module cpu_prefetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int AWID       = 10,
  parameter int PCW        = 19,
  parameter int IWID       = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int COLD_DELAY = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect_i,
  input  logic [PCW-1:0]  redirect_pc_i,
  input  logic            inst_ready_i,
  output logic            inst_valid_o,
  output logic [IWID-1:0] inst_o,
  output logic [PCW-1:0]  inst_pc_o,
  output logic            mem_rden_o,
  output logic [AWID-1:0] mem_addr_o,
  input  logic [IWID-1:0] mem_data_i,
  output logic [PCW-1:0]  nxt_pc_o
`ifdef CPU_PREFETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     flush_cnt_o
`endif
);

  localparam int CW  = cnt_w(FIFO_DEPTH);
  localparam int LW  = $clog2(MEM_LAT + 1);
  localparam int SW  = ((CW > LW) ? CW : LW) + 1;
  localparam int CDW = $clog2(COLD_DELAY + 1);
  localparam int FW  = IWID + PCW;

  fetch_state_t    r_state;
  logic [CDW-1:0]  r_cold_cnt;
  logic [PCW-1:0]  r_pc;
  inflight_t       r_pipe [MEM_LAT];

  inflight_t       w_issue_entry;
  inflight_t       w_tail;
  logic [PCW-1:0]  w_resp_pc;
  logic [LW-1:0]   w_inflight_cnt;
  logic [SW-1:0]   w_occupancy;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic [FW-1:0]   w_head;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;

  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_inflight_cnt = w_inflight_cnt + LW'(r_pipe[i].valid);
    end
  end

  // Buffered plus outstanding words never exceed the FIFO, so every response has a slot.
  assign w_occupancy   = SW'(w_fifo_count) + SW'(w_inflight_cnt);
  assign w_issue       = (r_state == FETCH) && !redirect_i && (w_occupancy < SW'(FIFO_DEPTH));
  assign w_issue_entry = '{valid: w_issue, pc: MAX_PCW'(r_pc)};

  assign mem_rden_o = w_issue;
  assign mem_addr_o = r_pc[AWID-1:0];
  assign nxt_pc_o   = r_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= COLD;
      r_cold_cnt <= CDW'(COLD_DELAY);
      r_pc       <= '0;
    end else begin
      case (r_state)
        COLD: begin
          if (r_cold_cnt == CDW'(1)) begin
            r_cold_cnt <= '0;
            r_state    <= FETCH;
          end else begin
            r_cold_cnt <= r_cold_cnt - CDW'(1);
          end
        end
        FETCH:   r_state <= FETCH;
        default: r_state <= COLD;
      endcase
      if (redirect_i) begin
        r_pc <= redirect_pc_i;
      end else if (w_issue) begin
        r_pc <= r_pc + PCW'(1);
      end
    end
  end

  // Read tracking: stage 0 holds the read issued last cycle; the last stage lines up with mem_data_i.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
    end else if (redirect_i) begin
      for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_issue_entry;
      for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail    = r_pipe[MEM_LAT-1];
  assign w_resp_pc = w_tail.pc[PCW-1:0];
  assign w_push    = w_tail.valid;
  assign w_pop     = inst_valid_o && inst_ready_i;

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_data  ({mem_data_i, w_resp_pc}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign inst_valid_o = !w_fifo_empty;
  assign inst_o       = w_fifo_empty ? '0 : w_head[FW-1:PCW];
  assign inst_pc_o    = w_fifo_empty ? '0 : w_head[PCW-1:0];

  assert property (@(posedge clk) disable iff (!resetn)
    !(w_push && w_fifo_full && !w_pop && !redirect_i));
  assert property (@(posedge clk) disable iff (!resetn)
    ((w_tail.pc >> PCW) == '0));

`ifdef CPU_PREFETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_discard;

  // A redirect only counts as a flush when it actually throws work away.
  assign w_discard = !w_fifo_empty || (w_inflight_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_issue && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (redirect_i && w_discard && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
// Scoreboard bench for cpu_prefetch_unit: directed stimulus queues expected {pc, inst}, a negedge monitor checks pops.
module tb_cpu_prefetch_unit;

  localparam int AWID       = 10;
  localparam int PCW        = 19;
  localparam int IWID       = 32;
  localparam int MEM_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int COLD_DELAY = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            redirect_i;
  logic [PCW-1:0]  redirect_pc_i;
  logic            inst_ready_i;
  logic            inst_valid_o;
  logic [IWID-1:0] inst_o;
  logic [PCW-1:0]  inst_pc_o;
  logic            mem_rden_o;
  logic [AWID-1:0] mem_addr_o;
  logic [IWID-1:0] mem_data_i;
  logic [PCW-1:0]  nxt_pc_o;
`ifdef CPU_PREFETCH_PERF_EN
  logic [31:0]     fetch_cnt_o;
  logic [31:0]     flush_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_prefetch_unit #(
    .AWID       (AWID),
    .PCW        (PCW),
    .IWID       (IWID),
    .MEM_LAT    (MEM_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .COLD_DELAY (COLD_DELAY)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_ready_i  (inst_ready_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .mem_rden_o    (mem_rden_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .nxt_pc_o      (nxt_pc_o)
`ifdef CPU_PREFETCH_PERF_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  function automatic logic [IWID-1:0] model_word(input logic [AWID-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Memory model: data for an address appears MEM_LAT cycles after the read strobe.
  logic [AWID-1:0] mq [MEM_LAT];
  always @(posedge clk) begin
    mq[0] <= mem_addr_o;
    for (int i = 1; i < MEM_LAT; i++) mq[i] <= mq[i-1];
  end
  assign mem_data_i = model_word(mq[MEM_LAT-1]);

  typedef struct packed {
    logic [PCW-1:0]  pc;
    logic [IWID-1:0] inst;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [PCW-1:0] pc);
    sb_q.push_back('{pc: pc, inst: model_word(pc[AWID-1:0])});
  endtask

  // Monitor: every accepted pop must match the next queued expectation; held heads must not change.
  exp_t mon_e;
  exp_t mon_prev;
  bit   mon_hold = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (mon_hold && inst_valid_o) begin
        check("hold_pc", 64'(inst_pc_o), 64'(mon_prev.pc));
        check("hold_inst", 64'(inst_o), 64'(mon_prev.inst));
      end
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got pc 0x%0h, expected no output", inst_pc_o);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_pc", 64'(inst_pc_o), 64'(mon_e.pc));
          check("out_inst", 64'(inst_o), 64'(mon_e.inst));
          $display("pop pc=0x%0h inst=0x%0h", inst_pc_o, inst_o);
        end
      end
      mon_hold = inst_valid_o && !inst_ready_i && !redirect_i;
      mon_prev = '{pc: inst_pc_o, inst: inst_o};
    end else begin
      mon_hold = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    inst_ready_i = 1'b1;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    inst_ready_i = 1'b0;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: %0d entries left, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
    check({tag, "_inst"}, 64'(inst_o), 64'd0);
    check({tag, "_inst_pc"}, 64'(inst_pc_o), 64'd0);
    check({tag, "_rden"}, 64'(mem_rden_o), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
    check({tag, "_nxt_pc"}, 64'(nxt_pc_o), 64'd0);
`ifdef CPU_PREFETCH_PERF_EN
    check({tag, "_fetch_cnt"}, 64'(fetch_cnt_o), 64'd0);
    check({tag, "_flush_cnt"}, 64'(flush_cnt_o), 64'd0);
`endif
  endtask

  // Called in the first cycle after reset release; reads at cycles 3..6, first output at cycle 6.
  task automatic cold_start(input logic [PCW-1:0] base, input bit redir);
    for (int c = 0; c < 10; c++) begin
      if (redir) begin
        redirect_i    = (c == 1);
        redirect_pc_i = base;
      end
      @(negedge clk);
      check("cold_rden", 64'(mem_rden_o), 64'((c >= 3 && c <= 6) ? 1 : 0));
      if (c >= 3 && c <= 6) check("cold_addr", 64'(mem_addr_o), 64'(base[AWID-1:0]) + 64'(c - 3));
      check("cold_valid", 64'(inst_valid_o), 64'((c >= 6) ? 1 : 0));
      @(posedge clk);
      #1;
    end
    redirect_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    resetn        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;
    step(2);
    @(negedge clk);
    check_all_zero("reset");

    // Cold start with backpressure: exactly four reads, then stall at pc 4.
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cold_start('0, 1'b0);
    @(negedge clk);
    check("bp_nxt_pc", 64'(nxt_pc_o), 64'd4);
    check("bp_rden", 64'(mem_rden_o), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) expect_pc(PCW'(i));
    drain("backpressure");
    step(12);
    @(negedge clk);
    check("refill_nxt_pc", 64'(nxt_pc_o), 64'd12);
    check("refill_head_pc", 64'(inst_pc_o), 64'd8);
    check("refill_rden", 64'(mem_rden_o), 64'd0);

    // Redirect with two reads (pcs 12, 13) in flight; 10..13 must never appear.
    @(posedge clk);
    #1;
    expect_pc(PCW'(8));
    expect_pc(PCW'(9));
    drain("pre_redirect");
    step(1);
    redirect_i    = 1'b1;
    redirect_pc_i = 19'h00100;
    @(negedge clk);
    check("redir_rden_r", 64'(mem_rden_o), 64'd0);
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    @(negedge clk);
    check("redir_rden_r1", 64'(mem_rden_o), 64'd1);
    check("redir_addr_r1", 64'(mem_addr_o), 64'h100);
    check("redir_valid_r1", 64'(inst_valid_o), 64'd0);
    check("redir_nxt_pc_r1", 64'(nxt_pc_o), 64'h100);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) expect_pc(PCW'(32'h100 + i));
    drain("redirect");

    // PC wrap at the top of the 19-bit space.
    step(10);
    redirect_i    = 1'b1;
    redirect_pc_i = 19'h7FFFF;
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    @(negedge clk);
    check("wrap_addr0", 64'(mem_addr_o), 64'h3FF);
    check("wrap_nxt0", 64'(nxt_pc_o), 64'h7FFFF);
    check("wrap_rden0", 64'(mem_rden_o), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wrap_addr1", 64'(mem_addr_o), 64'h000);
    check("wrap_nxt1", 64'(nxt_pc_o), 64'h00000);
    check("wrap_rden1", 64'(mem_rden_o), 64'd1);
    @(posedge clk);
    #1;
    expect_pc(19'h7FFFF);
    expect_pc(19'h00000);
    expect_pc(19'h00001);
    drain("wrap");

    // Pop coinciding with redirect is ignored and the FIFO ends empty.
    step(10);
    @(negedge clk);
    check("popredir_full_valid", 64'(inst_valid_o), 64'd1);
    @(posedge clk);
    #1;
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 19'h00200;
    @(posedge clk);
    #1;
    inst_ready_i = 1'b0;
    redirect_i   = 1'b0;
    @(negedge clk);
    check("popredir_valid", 64'(inst_valid_o), 64'd0);
    check("popredir_nxt_pc", 64'(nxt_pc_o), 64'h200);
    check("popredir_rden", 64'(mem_rden_o), 64'd1);
    @(posedge clk);
    #1;
    expect_pc(19'h00200);
    expect_pc(19'h00201);
    drain("popredir");

    // Asynchronous reset mid-cycle with a full FIFO, then a redirect during the cold countdown.
    step(10);
    #2;
    check("prereset_valid", 64'(inst_valid_o), 64'd1);
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cold_start(19'h00300, 1'b1);
    for (int i = 0; i < 6; i++) expect_pc(PCW'(32'h300 + i));
    drain("post_reset");
    step(12);
    @(negedge clk);
    check("post_reset_nxt_pc", 64'(nxt_pc_o), 64'h30A);
`ifdef CPU_PREFETCH_PERF_EN
    check("perf_fetch_pre", 64'(fetch_cnt_o), 64'd10);
    check("perf_flush_pre", 64'(flush_cnt_o), 64'd0);
`endif
    @(posedge clk);
    #1;
    redirect_i    = 1'b1;
    redirect_pc_i = 19'h00400;
    @(negedge clk);
    check("final_redir_rden", 64'(mem_rden_o), 64'd0);
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    @(negedge clk);
    check("final_redir_valid", 64'(inst_valid_o), 64'd0);
`ifdef CPU_PREFETCH_PERF_EN
    check("perf_fetch_post", 64'(fetch_cnt_o), 64'd10);
    check("perf_flush_post", 64'(flush_cnt_o), 64'd1);
`endif
    @(posedge clk);
    #1;
    expect_pc(19'h00400);
    drain("final");
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
